// File: rtl/ir_frame_encoder_pkg.sv
// Shared NEC IR definitions: FSM states and protocol segment lengths in units.
// Also intended for the IR receive decoder.
package ir_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    REP_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } ir_state_e;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int REP_SPACE_U  = 4;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_U       = 1;
  localparam int FRAME_BITS   = 32;

endpackage

// File: rtl/ir_frame_encoder_if.sv
// Request handshake into the IR frame encoder.
// The master drives the request fields; the slave returns ready.
interface ir_frame_encoder_if;
  logic       valid_in;
  logic       ready_out;
  logic       repeat_in;
  logic [7:0] addr_in;
  logic [7:0] cmd_in;

  modport master (output valid_in, repeat_in, addr_in, cmd_in, input ready_out);
  modport slave  (input valid_in, repeat_in, addr_in, cmd_in, output ready_out);
endinterface

// File: rtl/ir_frame_encoder_unit.sv
// NEC unit timer: counts clk cycles while enabled and pulses unit_tick on the last
// cycle of every unit. Held at zero when disabled, restarted on segment start.
module ir_unit_timer #(
  parameter int UNIT_CYCLES = 56_250
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic enable,
  input  logic clear,
  output logic unit_tick
);
  localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  logic [CNT_W-1:0] unit_cnt;

  assign unit_tick = enable && (unit_cnt == CNT_W'(UNIT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      unit_cnt <= '0;
    end else if (!enable || clear || unit_tick) begin
      unit_cnt <= '0;
    end else begin
      unit_cnt <= unit_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ir_frame_encoder.sv
// NEC IR frame encoder: serialises address/command (or a repeat code) into a
// carrier-on/off envelope for the 38 kHz carrier generator.
module ir_frame_encoder #(
  parameter int UNIT_CYCLES = 56_250,
  parameter int GAP_UNITS   = 72
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  ir_frame_encoder_if.slave req,
  output logic             burst_out,
  output logic             busy_out,
  output logic             done_out
);
  import ir_tx_pkg::*;

  localparam int MAX_SEG = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
  localparam int SEG_W   = $clog2(MAX_SEG + 1);

  ir_state_e             state, next_state;
  logic [SEG_W-1:0]      seg_cnt, seg_len;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bit_idx;
  logic                  rep_q;
  logic                  unit_tick, seg_end, accept;

  assign req.ready_out = (state == IDLE);
  assign busy_out      = (state != IDLE);
  assign accept        = req.valid_in && (state == IDLE);
  assign seg_end       = unit_tick && (seg_cnt == seg_len - SEG_W'(1));

  ir_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .enable    (state != IDLE),
    .clear     (seg_end),
    .unit_tick (unit_tick)
  );

  // Length of the current segment in units; bit spaces depend on the bit being sent.
  always_comb begin
    seg_len = SEG_W'(1);
    unique case (state)
      LEAD_MARK:  seg_len = SEG_W'(LEAD_MARK_U);
      LEAD_SPACE: seg_len = SEG_W'(LEAD_SPACE_U);
      REP_SPACE:  seg_len = SEG_W'(REP_SPACE_U);
      BIT_MARK:   seg_len = SEG_W'(BIT_MARK_U);
      BIT_SPACE:  seg_len = shreg[0] ? SEG_W'(ONE_SPACE_U) : SEG_W'(ZERO_SPACE_U);
      STOP_MARK:  seg_len = SEG_W'(STOP_U);
      GAP:        seg_len = SEG_W'(GAP_UNITS);
      default:    seg_len = SEG_W'(1);
    endcase
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (accept)  next_state = LEAD_MARK;
      LEAD_MARK:  if (seg_end) next_state = rep_q ? REP_SPACE : LEAD_SPACE;
      LEAD_SPACE: if (seg_end) next_state = BIT_MARK;
      REP_SPACE:  if (seg_end) next_state = STOP_MARK;
      BIT_MARK:   if (seg_end) next_state = BIT_SPACE;
      BIT_SPACE:
        if (seg_end) next_state = (bit_idx == 5'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (seg_end) next_state = GAP;
      GAP:        if (seg_end) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seg_cnt <= '0;
    end else if (state == IDLE || seg_end) begin
      seg_cnt <= '0;
    end else if (unit_tick) begin
      seg_cnt <= seg_cnt + SEG_W'(1);
    end
  end

  // burst_out is registered from next_state so the envelope is glitch-free.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      rep_q     <= 1'b0;
      burst_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      state     <= next_state;
      burst_out <= (next_state == LEAD_MARK) || (next_state == BIT_MARK) ||
                   (next_state == STOP_MARK);
      done_out  <= (state == STOP_MARK) && seg_end;
      if (accept) begin
        rep_q   <= req.repeat_in;
        shreg   <= {~req.cmd_in, req.cmd_in, ~req.addr_in, req.addr_in};
        bit_idx <= '0;
      end else if (state == BIT_SPACE && seg_end) begin
        shreg   <= {1'b0, shreg[FRAME_BITS-1:1]};
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end
endmodule
